mc_cu: RTL and testbench
========================

# mc_cu

Multi-cycle control unit for the MIPS-subset CPU: the successor to the single-cycle decoder. It supports the same instruction set, including the R-type `HAMM` (func 110000, ALU code 1011). It sequences each instruction through fetch/decode/execute/memory/write-back states over a shared memory port with a ready handshake. It adds a configurable multi-cycle Hamming ALU operation and a memory watchdog. It sits between the instruction register/ALU/z flag and the datapath muxes and write enables.

## Interface
- `HAMM_CYCLES`, 2: total EXE+HAMM cycles the ALU needs for `HAMM`; legal range 1..15.
- `MEM_TIMEOUT`, 0: maximum cycles to wait for `mem_ready`; 0 disables the watchdog; legal range 0..255.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op`, `func` in 6 each: fields of the instruction register; valid from ID onward.
- `z` in 1: ALU zero flag, combinational, sampled in EXE.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access active.
- `iord` out 1: address source; 0 = PC, 1 = ALU result register.
- `wir` out 1: IR write enable.
- `wpc` out 1: PC write enable.
- `wmem` out 1: memory write enable.
- `wreg` out 1: register file write enable.
- `regrt` out 1: destination is rt; otherwise rd.
- `m2reg` out 1: write-back data comes from the memory data register.
- `jal` out 1: write-back targets r31 and uses the PC as data.
- `shift` out 1: ALU A operand is the sa field.
- `sext` out 1: sign-extend the immediate.
- `alusrca` out 1: ALU A source; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B source; 00 = register B, 01 = constant 4, 10 = immediate, 11 = sign-extended immediate << 2.
- `aluc` out 4: ALU operation code.
- `pcsource` out 2: next-PC source; 00 = ALU, 01 = ALU-out register (branch target), 10 = register A (jr), 11 = jump address.
- `state` out 3: current FSM state, for debug.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `bus_err` out 1: one-cycle pulse on a watchdog expiry.

## Operation
- State encodings: IF=0, ID=1, EXE=2, MEM=3, WB=4, HAMM=5.
- Outputs are decoded combinationally from `state`, `op`, `func` and `z`. Every output is 0 in states where this section does not drive it.
- ALU codes:
  - add = 0000 (also used by `addi`, `lw`, `sw`, PC+4 and branch target)
  - sub = 0100 (also used by `beq`/`bne`)
  - and = 0001, or = 0101, xor = 0010, lui = 0110
  - sll = 0011, srl = 0111, sra = 1111, HAMM = 1011
- IF:
  - Drives `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, aluc add, pcsource 00.
  - On `mem_ready`: `wir`=1 and `wpc`=1, then go to ID.
- ID:
  - Drives `alusrca`=0, `alusrcb`=11, aluc add; the branch target is latched by the datapath.
  - `j`: `wpc`, pcsource 11, then IF.
  - `jal`: `wpc`, pcsource 11, `wreg`, `jal`, then IF.
  - `jr`: `wpc`, pcsource 10, then IF.
  - Undecodable op/func: `illegal`=1, no writes, then IF.
  - All other instructions: go to EXE.
- EXE:
  - `alusrca`=1. `shift`=1 for sll/srl/sra.
  - `alusrcb`=10 for I-type instructions, 00 for R-type. `sext` for addi/lw/sw/beq/bne.
  - `beq`/`bne`: aluc sub, pcsource 01, `wpc`=z for beq and ~z for bne, then IF.
  - `lw`/`sw`: go to MEM.
  - `HAMM`: go to WB if HAMM_CYCLES=1, otherwise go to HAMM.
  - All others: go to WB.
- HAMM:
  - Holds the EXE operand and aluc 1011 outputs.
  - Internal counter `hcnt` is cleared on EXE entry. The FSM leaves HAMM for WB when `hcnt` = HAMM_CYCLES-2.
- MEM:
  - Drives `mem_req`=1, `iord`=1; `wmem`=1 for sw for the whole wait.
  - On `mem_ready`: sw goes to IF, lw goes to WB.
- WB:
  - Drives `wreg`=1, then IF.
  - `m2reg`=1 for lw. `regrt`=1 for addi/andi/ori/xori/lw/lui.
- Watchdog (MEM_TIMEOUT>0):
  - Counter `wcnt` is cleared on entry to IF or MEM and increments each cycle the state waits without `mem_ready`.
  - When `wcnt` = MEM_TIMEOUT-1 and `mem_ready` is 0: `bus_err`=1, no `wir`/`wpc` writes, then IF. The PC is not advanced, so the fetch retries.
  - When MEM_TIMEOUT=0 the FSM waits indefinitely.
- Reset:
  - The cycle `reset` is sampled high, the next state is IF and `hcnt`/`wcnt` clear.
  - All write enables, `mem_req`, `illegal` and `bus_err` are forced to 0 while `reset`=1. This applies mid-instruction too: no partial writes.
- Simultaneous events: `mem_ready` arriving on the same cycle the watchdog expires counts as success.

## Timing
- Cycle counts with zero-wait memory (`mem_ready` held high):

  | Instruction | Cycles |
  |---|---|
  | j/jal/jr | 2 |
  | beq/bne | 3 |
  | sw | 4 |
  | R-type/I-type ALU | 4 |
  | lw | 5 |
  | HAMM | 3+HAMM_CYCLES |

- Each memory wait cycle adds 1 cycle.
- A write enable is asserted in exactly one cycle per instruction. The exception is `wmem`, which stays asserted across MEM wait cycles; memory commits the write on `mem_ready`.

## Test plan
- Reset then `mem_ready`=1 with `add`: state sequence 0,1,2,4,0; `wreg`=1 only in WB; aluc=0000; `regrt`=0.
- `lw` with `mem_ready` low for 3 cycles in MEM: `mem_req`=1 and `iord`=1 for 4 cycles; `m2reg`=1 and `wreg`=1 in WB; total 8 cycles.
- `beq` with z=1 then z=0: `wpc`=1 with pcsource=01 in EXE for z=1, `wpc`=0 for z=0; 3 cycles each.
- `HAMM` with HAMM_CYCLES=4: aluc=1011 for 4 cycles (EXE + 3 HAMM); `wreg` in cycle 7; HAMM_CYCLES=1 skips the HAMM state.
- MEM_TIMEOUT=5, `mem_ready` tied low in IF: `bus_err` pulses in the 5th IF cycle, no `wir`/`wpc`, IF is re-entered and the counter restarts.
- `reset` asserted in MEM during `sw`: `wmem`=0 that cycle and the next state is IF. Op 111111: `illegal` pulses in ID with no writes.

Source files
------------

// File: rtl/mc_cu.sv
// Multi-cycle control unit for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// over a shared ready-handshake memory port, with a multi-cycle HAMM op and a watchdog.
module mc_cu #(
   parameter int HAMM_CYCLES = 2,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       wir,
   output logic       wpc,
   output logic       wmem,
   output logic       wreg,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic       shift,
   output logic       sext,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic [2:0] state,
   output logic       illegal,
   output logic       bus_err
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HAMM = 3'd5
   } state_t;

   localparam logic [3:0] HAMM_LAST = 4'(HAMM_CYCLES > 1 ? HAMM_CYCLES - 2 : 0);
   localparam logic [7:0] WD_LAST   = 8'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

   state_t     state_q, state_d;
   logic [3:0] hcnt_q, hcnt_d;
   logic [7:0] wcnt_q, wcnt_d;

   logic       r_alu, r_shift, r_hamm, r_jr;
   logic       i_alu, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
   logic       legal, dec_sext, waiting, wd_exp;
   logic [3:0] alu_code;

   always_comb begin
      r_alu    = 1'b0;
      r_shift  = 1'b0;
      r_hamm   = 1'b0;
      r_jr     = 1'b0;
      i_alu    = 1'b0;
      i_lw     = 1'b0;
      i_sw     = 1'b0;
      i_beq    = 1'b0;
      i_bne    = 1'b0;
      i_j      = 1'b0;
      i_jal    = 1'b0;
      alu_code = 4'b0000;
      if (op == 6'b000000) begin
         case (func)
            6'b100000: r_alu = 1'b1;
            6'b100010: begin r_alu = 1'b1; alu_code = 4'b0100; end
            6'b100100: begin r_alu = 1'b1; alu_code = 4'b0001; end
            6'b100101: begin r_alu = 1'b1; alu_code = 4'b0101; end
            6'b100110: begin r_alu = 1'b1; alu_code = 4'b0010; end
            6'b000000: begin r_shift = 1'b1; alu_code = 4'b0011; end
            6'b000010: begin r_shift = 1'b1; alu_code = 4'b0111; end
            6'b000011: begin r_shift = 1'b1; alu_code = 4'b1111; end
            6'b001000: r_jr = 1'b1;
            6'b110000: begin r_hamm = 1'b1; alu_code = 4'b1011; end
            default: ;
         endcase
      end else begin
         case (op)
            6'b001000: i_alu = 1'b1;
            6'b001100: begin i_alu = 1'b1; alu_code = 4'b0001; end
            6'b001101: begin i_alu = 1'b1; alu_code = 4'b0101; end
            6'b001110: begin i_alu = 1'b1; alu_code = 4'b0010; end
            6'b001111: begin i_alu = 1'b1; alu_code = 4'b0110; end
            6'b100011: i_lw = 1'b1;
            6'b101011: i_sw = 1'b1;
            6'b000100: begin i_beq = 1'b1; alu_code = 4'b0100; end
            6'b000101: begin i_bne = 1'b1; alu_code = 4'b0100; end
            6'b000010: i_j = 1'b1;
            6'b000011: i_jal = 1'b1;
            default: ;
         endcase
      end
      legal    = r_alu | r_shift | r_hamm | r_jr | i_alu | i_lw | i_sw |
                 i_beq | i_bne | i_j | i_jal;
      dec_sext = (op == 6'b001000) | i_lw | i_sw | i_beq | i_bne;
   end

   assign waiting = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
   assign wd_exp  = (MEM_TIMEOUT > 0) && waiting && (wcnt_q == WD_LAST);
   assign state   = state_q;

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      iord     = 1'b0;
      wir      = 1'b0;
      wpc      = 1'b0;
      wmem     = 1'b0;
      wreg     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      shift    = 1'b0;
      sext     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluc     = 4'b0000;
      pcsource = 2'b00;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      case (state_q)
         S_IF: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            if (mem_ready) begin
               wir     = 1'b1;
               wpc     = 1'b1;
               state_d = S_ID;
            end else if (wd_exp) begin
               bus_err = 1'b1;
            end
         end
         S_ID: begin
            alusrcb = 2'b11;
            state_d = S_EXE;
            if (i_j || i_jal) begin
               wpc      = 1'b1;
               pcsource = 2'b11;
               wreg     = i_jal;
               jal      = i_jal;
               state_d  = S_IF;
            end else if (r_jr) begin
               wpc      = 1'b1;
               pcsource = 2'b10;
               state_d  = S_IF;
            end else if (!legal) begin
               illegal = 1'b1;
               state_d = S_IF;
            end
         end
         S_EXE: begin
            alusrca = 1'b1;
            shift   = r_shift;
            alusrcb = (i_alu || i_lw || i_sw) ? 2'b10 : 2'b00;
            sext    = dec_sext;
            aluc    = alu_code;
            if (i_beq || i_bne) begin
               pcsource = 2'b01;
               wpc      = i_beq ? z : ~z;
               state_d  = S_IF;
            end else if (i_lw || i_sw) begin
               state_d = S_MEM;
            end else if (r_hamm && HAMM_CYCLES > 1) begin
               state_d = S_HAMM;
            end else begin
               state_d = S_WB;
            end
         end
         S_HAMM: begin
            alusrca = 1'b1;
            aluc    = 4'b1011;
            if (hcnt_q == HAMM_LAST) state_d = S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            wmem    = i_sw;
            if (mem_ready) begin
               state_d = i_lw ? S_WB : S_IF;
            end else if (wd_exp) begin
               bus_err = 1'b1;
               state_d = S_IF;
            end
         end
         S_WB: begin
            wreg    = 1'b1;
            m2reg   = i_lw;
            regrt   = i_alu | i_lw;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
      // Reset aborts the instruction without any partial write reaching the datapath.
      if (reset) begin
         state_d = S_IF;
         wir     = 1'b0;
         wpc     = 1'b0;
         wmem    = 1'b0;
         wreg    = 1'b0;
         mem_req = 1'b0;
         illegal = 1'b0;
         bus_err = 1'b0;
      end
      hcnt_d = (!reset && state_q == S_HAMM) ? hcnt_q + 4'd1 : 4'd0;
      if (reset || bus_err || state_d != state_q) wcnt_d = 8'd0;
      else if (waiting)                            wcnt_d = wcnt_q + 8'd1;
      else                                         wcnt_d = wcnt_q;
   end

   always_ff @(posedge clock) begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      wcnt_q  <= wcnt_d;
   end

endmodule

// File: tb/tb_mc_cu.sv
// Scoreboard bench for mc_cu: two instances (HAMM_CYCLES=4/MEM_TIMEOUT=5 and
// HAMM_CYCLES=1/no watchdog) driven by instruction-level stimulus, checked each cycle.
module tb_mc_cu;

   localparam int PH_IF = 0, PH_ID = 1, PH_EXE = 2, PH_MEM = 3, PH_WB = 4, PH_HAMM = 5;
   localparam logic [3:0] K_R = 0, K_SH = 1, K_HM = 2, K_JR = 3, K_I = 4, K_LW = 5,
                          K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_ILL = 11;
   localparam int NI = 23;

   typedef struct packed {
      logic [5:0] op;
      logic [5:0] func;
      logic [3:0] kind;
      logic [3:0] aluc;
      logic       sext;
   } ent_t;

   localparam ent_t TBL [NI] = '{
      '{6'b000000, 6'b100000, K_R,   4'b0000, 1'b0},  // add
      '{6'b000000, 6'b100010, K_R,   4'b0100, 1'b0},  // sub
      '{6'b000000, 6'b100100, K_R,   4'b0001, 1'b0},  // and
      '{6'b000000, 6'b100101, K_R,   4'b0101, 1'b0},  // or
      '{6'b000000, 6'b100110, K_R,   4'b0010, 1'b0},  // xor
      '{6'b000000, 6'b000000, K_SH,  4'b0011, 1'b0},  // sll
      '{6'b000000, 6'b000010, K_SH,  4'b0111, 1'b0},  // srl
      '{6'b000000, 6'b000011, K_SH,  4'b1111, 1'b0},  // sra
      '{6'b000000, 6'b001000, K_JR,  4'b0000, 1'b0},  // jr
      '{6'b000000, 6'b110000, K_HM,  4'b1011, 1'b0},  // hamm
      '{6'b001000, 6'b000000, K_I,   4'b0000, 1'b1},  // addi
      '{6'b001100, 6'b000000, K_I,   4'b0001, 1'b0},  // andi
      '{6'b001101, 6'b000000, K_I,   4'b0101, 1'b0},  // ori
      '{6'b001110, 6'b000000, K_I,   4'b0010, 1'b0},  // xori
      '{6'b001111, 6'b000000, K_I,   4'b0110, 1'b0},  // lui
      '{6'b100011, 6'b000000, K_LW,  4'b0000, 1'b1},  // lw
      '{6'b101011, 6'b000000, K_SW,  4'b0000, 1'b1},  // sw
      '{6'b000100, 6'b000000, K_BEQ, 4'b0100, 1'b1},  // beq
      '{6'b000101, 6'b000000, K_BNE, 4'b0100, 1'b1},  // bne
      '{6'b000010, 6'b000000, K_J,   4'b0000, 1'b0},  // j
      '{6'b000011, 6'b000000, K_JAL, 4'b0000, 1'b0},  // jal
      '{6'b111111, 6'b000000, K_ILL, 4'b0000, 1'b0},  // bad op
      '{6'b000000, 6'b111111, K_ILL, 4'b0000, 1'b0}   // bad func
   };

   typedef struct packed {
      logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, m2reg, jal, shift, sext, alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluc;
      logic [1:0] pcsource;
      logic [2:0] state;
      logic       illegal, bus_err;
   } out_t;

   logic       clock;
   logic       reset_s [2];
   logic       z_s [2];
   logic       rdy_s [2];
   logic [5:0] op_s [2];
   logic [5:0] func_s [2];
   wire  [24:0] av0, av1;

   out_t q0 [$];
   out_t q1 [$];
   int   total = 0;
   int   bad = 0;
   int   cyc_n = 0;
   bit   end_chk = 0;
   bit   end_done = 0;

   mc_cu #(.HAMM_CYCLES(4), .MEM_TIMEOUT(5)) u0 (
      .clock(clock), .reset(reset_s[0]), .op(op_s[0]), .func(func_s[0]), .z(z_s[0]),
      .mem_ready(rdy_s[0]), .mem_req(av0[24]), .iord(av0[23]), .wir(av0[22]), .wpc(av0[21]),
      .wmem(av0[20]), .wreg(av0[19]), .regrt(av0[18]), .m2reg(av0[17]), .jal(av0[16]),
      .shift(av0[15]), .sext(av0[14]), .alusrca(av0[13]), .alusrcb(av0[12:11]),
      .aluc(av0[10:7]), .pcsource(av0[6:5]), .state(av0[4:2]), .illegal(av0[1]),
      .bus_err(av0[0]));

   mc_cu #(.HAMM_CYCLES(1), .MEM_TIMEOUT(0)) u1 (
      .clock(clock), .reset(reset_s[1]), .op(op_s[1]), .func(func_s[1]), .z(z_s[1]),
      .mem_ready(rdy_s[1]), .mem_req(av1[24]), .iord(av1[23]), .wir(av1[22]), .wpc(av1[21]),
      .wmem(av1[20]), .wreg(av1[19]), .regrt(av1[18]), .m2reg(av1[17]), .jal(av1[16]),
      .shift(av1[15]), .sext(av1[14]), .alusrca(av1[13]), .alusrcb(av1[12:11]),
      .aluc(av1[10:7]), .pcsource(av1[6:5]), .state(av1[4:2]), .illegal(av1[1]),
      .bus_err(av1[0]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: what the unit must present in one cycle of a given instruction phase.
   function automatic out_t model(input int ph, input int k, input bit rdy, input bit zv,
                                  input bit rst, input bit expire);
      out_t       o;
      logic [3:0] kd;
      bit         we;
      o  = '0;
      kd = TBL[k].kind;
      we = !rst;
      case (ph)
         PH_IF: begin
            o.alusrcb = 2'b01;
            o.mem_req = we;
            o.wir     = we && rdy;
            o.wpc     = we && rdy;
            o.bus_err = we && expire;
         end
         PH_ID: begin
            o.state   = 3'd1;
            o.alusrcb = 2'b11;
            if (kd == K_J || kd == K_JAL) begin
               o.wpc = we; o.pcsource = 2'b11;
               o.wreg = we && (kd == K_JAL); o.jal = (kd == K_JAL);
            end
            if (kd == K_JR) begin o.wpc = we; o.pcsource = 2'b10; end
            o.illegal = we && (kd == K_ILL);
         end
         PH_EXE: begin
            o.state   = 3'd2;
            o.alusrca = 1'b1;
            o.shift   = (kd == K_SH);
            o.alusrcb = (kd == K_I || kd == K_LW || kd == K_SW) ? 2'b10 : 2'b00;
            o.sext    = TBL[k].sext;
            o.aluc    = TBL[k].aluc;
            if (kd == K_BEQ || kd == K_BNE) begin
               o.pcsource = 2'b01;
               o.wpc      = we && ((kd == K_BEQ) ? zv : !zv);
            end
         end
         PH_HAMM: begin
            o.state = 3'd5; o.alusrca = 1'b1; o.aluc = 4'b1011;
         end
         PH_MEM: begin
            o.state   = 3'd3;
            o.mem_req = we;
            o.iord    = 1'b1;
            o.wmem    = we && (kd == K_SW);
            o.bus_err = we && expire;
         end
         default: begin
            o.state = 3'd4;
            o.wreg  = we;
            o.m2reg = (kd == K_LW);
            o.regrt = (kd == K_I || kd == K_LW);
         end
      endcase
      return o;
   endfunction

   task automatic cyc(input int i, input int ph, input int k, input bit rdy, input bit zv,
                      input bit rst, input bit expire);
      out_t e;
      rdy_s[i]   = rdy;
      z_s[i]     = zv;
      reset_s[i] = rst;
      e = model(ph, k, rdy, zv, rst, expire);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Memory wait: 'w' idle cycles before ready; the watchdog may cut it short.
   task automatic mem_phase(input int i, input int ph, input int k, input int w, input int to,
                            output bit ok);
      int left;
      left = w;
      ok   = 1'b0;
      forever begin
         if (to > 0 && left >= to) begin
            for (int c = 0; c < to; c++) cyc(i, ph, k, 1'b0, 1'($urandom), 1'b0, c == to - 1);
            left -= to;
            if (ph == PH_MEM) return;
         end else begin
            for (int c = 0; c < left; c++) cyc(i, ph, k, 1'b0, 1'($urandom), 1'b0, 1'b0);
            cyc(i, ph, k, 1'b1, 1'($urandom), 1'b0, 1'b0);
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic run_instr(input int i, input int k, input int fw, input int mw, input bit zv,
                            input bit rst_mem, input int hc, input int to);
      logic [3:0] kd;
      bit         ok;
      kd        = TBL[k].kind;
      op_s[i]   = TBL[k].op;
      func_s[i] = (TBL[k].op == 6'b000000) ? TBL[k].func : 6'($urandom_range(0, 63));
      mem_phase(i, PH_IF, k, fw, to, ok);
      cyc(i, PH_ID, k, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (kd == K_J || kd == K_JAL || kd == K_JR || kd == K_ILL) return;
      cyc(i, PH_EXE, k, 1'($urandom), zv, 1'b0, 1'b0);
      if (kd == K_BEQ || kd == K_BNE) return;
      if (kd == K_HM)
         for (int c = 0; c < hc - 1; c++) cyc(i, PH_HAMM, k, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (kd == K_LW || kd == K_SW) begin
         if (rst_mem) begin
            cyc(i, PH_MEM, k, 1'b0, 1'b0, 1'b1, 1'b0);
            return;
         end
         mem_phase(i, PH_MEM, k, mw, to, ok);
         if (!ok || kd == K_SW) return;
      end
      cyc(i, PH_WB, k, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
   endtask

   task automatic run_rand(input int i, input int n, input int hc, input int to);
      int k, fw, mw;
      for (int t = 0; t < n; t++) begin
         k  = $urandom_range(0, NI - 1);
         fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
         mw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 0;
         run_instr(i, k, fw, mw, 1'($urandom), 1'b0, hc, to);
      end
   endtask

   task automatic drive0();
      cyc(0, PH_IF, 0, 1'b0, 1'b0, 1'b1, 1'b0);     // reset state
      run_instr(0, 0, 0, 0, 1'b0, 1'b0, 4, 5);      // add
      run_instr(0, 15, 0, 3, 1'b0, 1'b0, 4, 5);     // lw, 3 MEM waits
      run_instr(0, 17, 0, 0, 1'b1, 1'b0, 4, 5);     // beq taken
      run_instr(0, 17, 0, 0, 1'b0, 1'b0, 4, 5);     // beq not taken
      run_instr(0, 9, 0, 0, 1'b0, 1'b0, 4, 5);      // hamm
      run_instr(0, 0, 5, 0, 1'b0, 1'b0, 4, 5);      // fetch watchdog expiry, retry
      run_instr(0, 1, 4, 4, 1'b0, 1'b0, 4, 5);      // ready on the expiry cycle
      run_instr(0, 15, 0, 4, 1'b0, 1'b0, 4, 5);
      run_instr(0, 16, 0, 6, 1'b0, 1'b0, 4, 5);     // sw watchdog in MEM
      run_instr(0, 16, 0, 0, 1'b0, 1'b1, 4, 5);     // reset during sw MEM
      run_instr(0, 21, 0, 0, 1'b0, 1'b0, 4, 5);     // illegal op
      run_instr(0, 22, 0, 0, 1'b0, 1'b0, 4, 5);     // illegal func
      run_rand(0, 150, 4, 5);
   endtask

   task automatic drive1();
      cyc(1, PH_IF, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_instr(1, 9, 0, 0, 1'b0, 1'b0, 1, 0);      // hamm skips HAMM state
      run_instr(1, 15, 9, 12, 1'b0, 1'b0, 1, 0);    // long waits, no watchdog
      run_instr(1, 18, 0, 0, 1'b0, 1'b0, 1, 0);     // bne taken
      run_rand(1, 150, 1, 0);
   endtask

   always @(negedge clock) begin
      out_t e;
      cyc_n++;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         total++;
         if (av0 !== e) begin
            bad++;
            $display("FAIL u0_outputs cyc=%0d got=%h want=%h (state got %0d want %0d)",
                     cyc_n, av0, e, av0[4:2], e.state);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         total++;
         if (av1 !== e) begin
            bad++;
            $display("FAIL u1_outputs cyc=%0d got=%h want=%h (state got %0d want %0d)",
                     cyc_n, av1, e, av1[4:2], e.state);
         end
      end
      if (end_chk && !end_done) begin
         end_done = 1'b1;
         total++;
         if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q0.size() + q1.size());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "time limit");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_s[i] = 1'b1;
         z_s[i]     = 1'b0;
         rdy_s[i]   = 1'b0;
         op_s[i]    = 6'd0;
         func_s[i]  = 6'd0;
      end
      @(posedge clock);
      #1;
      fork
         drive0();
         drive1();
      join
      end_chk = 1'b1;
      repeat (3) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
